// File: rtl/mem_arbiter.sv
// Arbitrates one MMU port between instruction fetch and data accesses.
// Data beats fetch; each access takes one cycle and all outputs are registered.
module mem_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        mem_misalign_o,
  output logic        busy_o,
  output logic        mmu_read_o,
  output logic        mmu_write_o,
  output logic [31:0] mmu_addr_o,
  output logic [31:0] mmu_wdata_o,
  output logic [4:0]  mmu_bytemode_o,
  input  logic [31:0] mmu_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_D_ACC = 2'b01,
    ST_I_ACC = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_misalign_q, mem_misalign_d;
  logic        mmu_read_q, mmu_read_d;
  logic        mmu_write_q, mmu_write_d;
  logic [31:0] mmu_addr_q, mmu_addr_d;
  logic [31:0] mmu_wdata_q, mmu_wdata_d;
  logic [4:0]  mmu_bytemode_q, mmu_bytemode_d;
  logic        mem_bad_s;
  logic [4:0]  mem_bm_s;
  logic [1:0]  unused_if_addr_lsb;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lsb[0];
      default: bad = (lsb != 2'b00);
    endcase
    return bad;
  endfunction

  // Size 11 behaves as a word; the unsigned flag only applies to sub-word loads.
  function automatic logic [4:0] data_bytemode(input logic [1:0] size, input logic [1:0] lsb,
                                               input logic uns, input logic we);
    logic       u;
    logic [3:0] lanes;
    logic [4:0] bm;
    u     = uns & ~we;
    lanes = 4'b0001;
    bm    = 5'b01111;
    case (size)
      2'b00: begin
        case (lsb)
          2'b00:   lanes = 4'b0001;
          2'b01:   lanes = 4'b0010;
          2'b10:   lanes = 4'b0100;
          default: lanes = 4'b1000;
        endcase
        bm = {u, lanes};
      end
      2'b01:   bm = {u, (lsb[1] ? 4'b1100 : 4'b0011)};
      default: bm = 5'b01111;
    endcase
    return bm;
  endfunction

  assign mem_bad_s          = is_misaligned(mem_size_i, mem_addr_i[1:0]);
  assign mem_bm_s           = data_bytemode(mem_size_i, mem_addr_i[1:0], mem_unsigned_i, mem_we_i);
  assign unused_if_addr_lsb = if_addr_i[1:0];

  // Next-state and next-output logic; requests are only looked at in IDLE and on D_ACC exit.
  always_comb begin
    state_d        = state_q;
    if_rdata_d     = if_rdata_q;
    if_ready_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    mem_ready_d    = 1'b0;
    mem_misalign_d = 1'b0;
    mmu_read_d     = 1'b0;
    mmu_write_d    = 1'b0;
    mmu_addr_d     = mmu_addr_q;
    mmu_wdata_d    = mmu_wdata_q;
    mmu_bytemode_d = mmu_bytemode_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          if (mem_bad_s) begin
            mem_ready_d    = 1'b1;
            mem_misalign_d = 1'b1;
          end else begin
            state_d        = ST_D_ACC;
            mmu_read_d     = ~mem_we_i;
            mmu_write_d    = mem_we_i;
            mmu_addr_d     = mem_addr_i;
            mmu_wdata_d    = mem_wdata_i;
            mmu_bytemode_d = mem_bm_s;
          end
        end else if (if_req_i) begin
          state_d        = ST_I_ACC;
          mmu_read_d     = 1'b1;
          mmu_addr_d     = {if_addr_i[31:2], 2'b00};
          mmu_bytemode_d = 5'b01111;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_D_ACC: begin
        mem_ready_d = 1'b1;
        if (mmu_read_q) begin
          mem_rdata_d = mmu_rdata_i;
        end else begin
          mem_rdata_d = mem_rdata_q;
        end
        if (if_req_i) begin
          state_d        = ST_I_ACC;
          mmu_read_d     = 1'b1;
          mmu_addr_d     = {if_addr_i[31:2], 2'b00};
          mmu_bytemode_d = 5'b01111;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_I_ACC: begin
        if_rdata_d = mmu_rdata_i;
        if_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      if_rdata_q     <= 32'h0000_0000;
      if_ready_q     <= 1'b0;
      mem_rdata_q    <= 32'h0000_0000;
      mem_ready_q    <= 1'b0;
      mem_misalign_q <= 1'b0;
      mmu_read_q     <= 1'b0;
      mmu_write_q    <= 1'b0;
      mmu_addr_q     <= 32'h0000_0000;
      mmu_wdata_q    <= 32'h0000_0000;
      mmu_bytemode_q <= 5'b00000;
    end else begin
      state_q        <= state_d;
      if_rdata_q     <= if_rdata_d;
      if_ready_q     <= if_ready_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_ready_q    <= mem_ready_d;
      mem_misalign_q <= mem_misalign_d;
      mmu_read_q     <= mmu_read_d;
      mmu_write_q    <= mmu_write_d;
      mmu_addr_q     <= mmu_addr_d;
      mmu_wdata_q    <= mmu_wdata_d;
      mmu_bytemode_q <= mmu_bytemode_d;
    end
  end

  assign if_rdata_o     = if_rdata_q;
  assign if_ready_o     = if_ready_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_ready_o    = mem_ready_q;
  assign mem_misalign_o = mem_misalign_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign mmu_read_o     = mmu_read_q;
  assign mmu_write_o    = mmu_write_q;
  assign mmu_addr_o     = mmu_addr_q;
  assign mmu_wdata_o    = mmu_wdata_q;
  assign mmu_bytemode_o = mmu_bytemode_q;

endmodule
